// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, 1 or 2 stop bits, optional parity.
// Parity support is compiled in when the UART_RX_PARITY_EN macro is defined.
module uart_rx_cfg #(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (BAUD_DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_out_reg, data_out_next;
  logic                 ferr_reg, ferr_next;
  logic                 done_reg, done_next;
  logic                 sync0_reg, sync1_reg, rx_prev_reg;
  logic                 rx_s;
  logic                 pulse;

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_SENSE = (PARITY_ODD != 0);
  logic perr_reg, perr_next;
`endif

  assign rx_s = sync1_reg;

  // Sync flops and the edge-detect history idle high so reset never fakes a break.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_reg   <= 1'b1;
      sync1_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync0_reg   <= rx;
      sync1_reg   <= sync0_reg;
      rx_prev_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      data_out_reg <= '0;
      ferr_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      data_out_reg <= data_out_next;
      ferr_reg     <= ferr_next;
      done_reg     <= done_next;
`ifdef UART_RX_PARITY_EN
      perr_reg     <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    data_out_next = data_out_reg;
    ferr_next     = ferr_reg;
    done_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next     = perr_reg;
`endif
    case (state_reg)
      IDLE: begin
        ferr_next = 1'b0;
        bit_next  = '0;
`ifdef UART_RX_PARITY_EN
        perr_next = 1'b0;
`endif
        if (rx_prev_reg && !rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // The count reaches BAUD_DIV/2 on this edge: mid start bit.
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          perr_next  = (^shift_reg) ^ rx_s ^ ODD_SENSE;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        // done_reg marks the one-cycle result slot after the last stop sample.
        if (done_reg) begin
          state_next = ferr_reg ? WAIT_IDLE : IDLE;
        end else if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            ferr_next = 1'b1;
          end
          if (bit_reg == STOP_LAST) begin
            done_next = 1'b1;
            if (rx_s && !ferr_reg) begin
              data_out_next = shift_reg;
            end
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pulse      = (state_reg == STOP) && done_reg;
  assign data_out   = data_out_reg;
  assign data_valid = pulse && !ferr_reg;
  assign frame_err  = pulse && ferr_reg;
  assign busy       = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = pulse && !ferr_reg && perr_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule
